// File: rtl/dcache_flush_walker_if.sv
// Tag-array and write-back port bundle of the data-cache flush walker.
// The master side belongs to the walker, the slave side to the tag array / write-back unit.
interface dcache_flush_walker_if #(
  parameter int NR_SETS  = 256,
  parameter int NR_WAYS  = 8,
  parameter int TAG_W    = 44,
  parameter int OFFSET_W = 4
);
  localparam int IDX_W  = $clog2(NR_SETS);
  localparam int WAY_W  = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
  localparam int ADDR_W = TAG_W + IDX_W + OFFSET_W;

  // Handshakes: a request holds its payload stable until the cycle in which the
  // matching grant is high; request and grant high together on a clock edge is a transfer.
  logic                     tag_req_o;
  logic                     tag_we_o;
  logic [IDX_W-1:0]         tag_idx_o;
  logic [NR_WAYS-1:0]       tag_way_be_o;
  logic                     tag_gnt_i;
  logic [NR_WAYS-1:0]       tag_valid_i;
  logic [NR_WAYS-1:0]       tag_dirty_i;
  logic [NR_WAYS*TAG_W-1:0] tag_rdata_i;
  logic                     wb_req_o;
  logic [ADDR_W-1:0]        wb_addr_o;
  logic [WAY_W-1:0]         wb_way_o;
  logic                     wb_gnt_i;

  modport master (
    output tag_req_o, tag_we_o, tag_idx_o, tag_way_be_o,
    input  tag_gnt_i, tag_valid_i, tag_dirty_i, tag_rdata_i,
    output wb_req_o, wb_addr_o, wb_way_o,
    input  wb_gnt_i
  );

  modport slave (
    input  tag_req_o, tag_we_o, tag_idx_o, tag_way_be_o,
    output tag_gnt_i, tag_valid_i, tag_dirty_i, tag_rdata_i,
    input  wb_req_o, wb_addr_o, wb_way_o,
    output wb_gnt_i
  );
endinterface

// File: rtl/dcache_flush_walker.sv
// Write-back data-cache flush engine: walks every set, writes back valid+dirty
// lines lowest way first, invalidates the set, then pulses flush_ack_o once.
module dcache_flush_walker #(
  parameter int NR_SETS  = 256,
  parameter int NR_WAYS  = 8,
  parameter int TAG_W    = 44,
  parameter int OFFSET_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 flush_i,
  output logic                 flush_ack_o,
  output logic                 busy_o,
  output logic [2:0]           state_o,
  dcache_flush_walker_if.master bus
);
  localparam int IDX_W = $clog2(NR_SETS);
  localparam int WAY_W = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_READ       = 3'd1;
  localparam logic [2:0] S_INSPECT    = 3'd2;
  localparam logic [2:0] S_WRITEBACK  = 3'd3;
  localparam logic [2:0] S_INVALIDATE = 3'd4;
  localparam logic [2:0] S_ACK        = 3'd5;

  logic [2:0]               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NR_WAYS-1:0]       pending_q, pending_d;
  logic [NR_WAYS*TAG_W-1:0] tags_q, tags_d;
  logic                     armed_q, armed_d;

  logic [WAY_W-1:0]         wb_way;
  logic [NR_WAYS-1:0]       wb_onehot;

  // Lowest pending way: descending scan so the last hit wins.
  always_comb begin
    wb_way    = '0;
    wb_onehot = '0;
    for (int w = NR_WAYS - 1; w >= 0; w--) begin
      if (pending_q[w]) begin
        wb_way       = WAY_W'(w);
        wb_onehot    = '0;
        wb_onehot[w] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    pending_d        = pending_q;
    tags_d           = tags_q;
    // A low flush_i re-arms; only a fresh request after a low cycle may start a walk.
    armed_d          = armed_q | ~flush_i;
    flush_ack_o      = 1'b0;
    bus.tag_req_o    = 1'b0;
    bus.tag_we_o     = 1'b0;
    bus.tag_idx_o    = '0;
    bus.tag_way_be_o = '0;
    bus.wb_req_o     = 1'b0;
    bus.wb_addr_o    = '0;
    bus.wb_way_o     = '0;
    case (state_q)
      S_IDLE: begin
        if (flush_i && armed_q) begin
          state_d = S_READ;
          idx_d   = '0;
          armed_d = 1'b0;
        end
      end
      S_READ: begin
        bus.tag_req_o = 1'b1;
        bus.tag_idx_o = idx_q;
        if (bus.tag_gnt_i) state_d = S_INSPECT;
      end
      S_INSPECT: begin
        pending_d = bus.tag_valid_i & bus.tag_dirty_i;
        tags_d    = bus.tag_rdata_i;
        state_d   = (|(bus.tag_valid_i & bus.tag_dirty_i)) ? S_WRITEBACK : S_INVALIDATE;
      end
      S_WRITEBACK: begin
        bus.wb_req_o  = 1'b1;
        bus.wb_way_o  = wb_way;
        bus.wb_addr_o = {tags_q[int'(wb_way)*TAG_W +: TAG_W], idx_q, OFFSET_W'(0)};
        if (bus.wb_gnt_i) begin
          pending_d = pending_q & ~wb_onehot;
          if ((pending_q & ~wb_onehot) == '0) state_d = S_INVALIDATE;
        end
      end
      S_INVALIDATE: begin
        bus.tag_req_o    = 1'b1;
        bus.tag_we_o     = 1'b1;
        bus.tag_way_be_o = '1;
        bus.tag_idx_o    = idx_q;
        if (bus.tag_gnt_i) begin
          if (idx_q == IDX_W'(NR_SETS - 1)) begin
            state_d = S_ACK;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_ACK: begin
        flush_ack_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      pending_q <= '0;
      tags_q    <= '0;
      armed_q   <= 1'b1;
    end else if (clr_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      pending_q <= '0;
      tags_q    <= '0;
      armed_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      tags_q    <= tags_d;
      armed_q   <= armed_d;
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign state_o = state_q;
endmodule

// File: tb/tb_dcache_flush_walker.sv
// Self-checking bench for dcache_flush_walker: a behavioural tag-array model answers the
// walker, and a scoreboard predicts write-backs, invalidates and the acknowledge cycle.
module tb_dcache_flush_walker;
  localparam int NR_SETS   = 4;
  localparam int NR_WAYS   = 2;
  localparam int TAG_W     = 8;
  localparam int OFFSET_W  = 4;
  localparam int IDX_W     = 2;
  localparam int WAY_W     = 1;
  localparam int ADDR_W    = TAG_W + IDX_W + OFFSET_W;
  localparam int RD_W      = NR_WAYS * TAG_W;
  localparam int CLEAN_LAT = 3 * NR_SETS + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       flush = 1'b0;
  logic       flush_ack, busy;
  logic [2:0] state;

  dcache_flush_walker_if #(.NR_SETS(NR_SETS), .NR_WAYS(NR_WAYS), .TAG_W(TAG_W), .OFFSET_W(OFFSET_W)) bus ();

  dcache_flush_walker #(.NR_SETS(NR_SETS), .NR_WAYS(NR_WAYS), .TAG_W(TAG_W), .OFFSET_W(OFFSET_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .flush_i(flush),
    .flush_ack_o(flush_ack), .busy_o(busy), .state_o(state), .bus(bus)
  );

  always #5 clk = ~clk;

  // Tag array contents
  logic [NR_WAYS-1:0] m_valid [NR_SETS];
  logic [NR_WAYS-1:0] m_dirty [NR_SETS];
  logic [TAG_W-1:0]   m_tag   [NR_SETS][NR_WAYS];

  logic [WAY_W+ADDR_W-1:0] exp_q[$];
  logic [IDX_W-1:0]        inv_q[$];

  int n_vec = 0, n_err = 0, cyc = 0;
  int start_cyc = 0, n_dirty = 0, stalls = 0, last_lat = -1, n_wb = 0;
  int rand_pct = 0, wb_stall_left = 0, tag_stall_left = 0;
  logic walking = 1'b0, armed_m = 1'b1;
  logic rd_pend = 1'b0;
  logic [IDX_W-1:0] rd_set = '0, tag_stall_set = '0;
  logic prev_wb_hold = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [WAY_W-1:0]  prev_way = '0;
  logic clr_on_wb = 1'b0, check_idle_next = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_all(input logic v, input logic d);
    for (int s = 0; s < NR_SETS; s++)
      for (int w = 0; w < NR_WAYS; w++) begin
        m_valid[s][w] = v;
        m_dirty[s][w] = d;
        m_tag[s][w]   = TAG_W'($urandom);
      end
  endtask

  task automatic fill_random();
    for (int s = 0; s < NR_SETS; s++)
      for (int w = 0; w < NR_WAYS; w++) begin
        m_valid[s][w] = 1'($urandom_range(1));
        m_dirty[s][w] = 1'($urandom_range(1));
        m_tag[s][w]   = TAG_W'($urandom);
      end
  endtask

  // Reference: every valid+dirty line in set/way order, then one invalidate per set.
  task automatic begin_walk();
    start_cyc = cyc;
    walking   = 1'b1;
    stalls    = 0;
    n_dirty   = 0;
    n_wb      = 0;
    exp_q.delete();
    inv_q.delete();
    for (int s = 0; s < NR_SETS; s++) begin
      for (int w = 0; w < NR_WAYS; w++)
        if (m_valid[s][w] && m_dirty[s][w]) begin
          exp_q.push_back({WAY_W'(w), m_tag[s][w], IDX_W'(s), OFFSET_W'(0)});
          n_dirty++;
        end
      inv_q.push_back(IDX_W'(s));
    end
  endtask

  // One clock cycle: entered and left #1 after a rising edge.
  task automatic cycle();
    logic tg, wg, start_now, exp_ack, abort, rd_nxt;
    logic [RD_W-1:0] rd;
    logic [IDX_W-1:0] rd_set_nxt;
    rd_nxt = 1'b0;
    rd_set_nxt = rd_set;
    if (rd_pend) begin
      for (int w = 0; w < NR_WAYS; w++) rd[w*TAG_W +: TAG_W] = m_tag[rd_set][w];
      bus.tag_valid_i = m_valid[rd_set];
      bus.tag_dirty_i = m_dirty[rd_set];
      bus.tag_rdata_i = rd;
    end else begin
      bus.tag_valid_i = NR_WAYS'($urandom);
      bus.tag_dirty_i = NR_WAYS'($urandom);
      bus.tag_rdata_i = RD_W'($urandom);
    end
    tg = ($urandom_range(99) >= rand_pct);
    wg = ($urandom_range(99) >= rand_pct);
    if (bus.tag_req_o && !bus.tag_we_o && bus.tag_idx_o == tag_stall_set && tag_stall_left > 0) begin
      tg = 1'b0;
      tag_stall_left--;
    end
    if (bus.wb_req_o && wb_stall_left > 0) begin
      wg = 1'b0;
      wb_stall_left--;
    end
    abort = clr_on_wb && bus.wb_req_o;
    if (abort) begin
      clr = 1'b1;
      flush = 1'b0;
      wg = 1'b0;
      clr_on_wb = 1'b0;
    end
    bus.tag_gnt_i = tg;
    bus.wb_gnt_i  = wg;
    start_now = !walking && flush && armed_m;
    if (start_now) begin_walk();
    #1;
    exp_ack = walking && !start_now && (cyc == start_cyc + CLEAN_LAT + n_dirty + stalls);
    check("busy", 64'(busy), 64'(walking && !start_now));
    check("ack", 64'(flush_ack), 64'(exp_ack));
    if (check_idle_next) begin
      check("clr_state", 64'(state), 64'(0));
      check("clr_tag_req", 64'(bus.tag_req_o), 64'(0));
      check("clr_tag_we", 64'(bus.tag_we_o), 64'(0));
      check("clr_tag_idx", 64'(bus.tag_idx_o), 64'(0));
      check("clr_wb_req", 64'(bus.wb_req_o), 64'(0));
      check_idle_next = 1'b0;
    end
    if (!walking || start_now) begin
      check("idle_tag_req", 64'(bus.tag_req_o), 64'(0));
      check("idle_wb_req", 64'(bus.wb_req_o), 64'(0));
    end
    check("way_be", 64'(bus.tag_way_be_o), 64'((bus.tag_req_o && bus.tag_we_o) ? {NR_WAYS{1'b1}} : {NR_WAYS{1'b0}}));
    if (!bus.wb_req_o) begin
      check("wb_addr_idle", 64'(bus.wb_addr_o), 64'(0));
      check("wb_way_idle", 64'(bus.wb_way_o), 64'(0));
    end
    if (prev_wb_hold) begin
      check("wb_hold_req", 64'(bus.wb_req_o), 64'(1));
      check("wb_hold_addr", 64'(bus.wb_addr_o), 64'(prev_addr));
      check("wb_hold_way", 64'(bus.wb_way_o), 64'(prev_way));
    end
    if (bus.tag_req_o && tg) begin
      if (bus.tag_we_o) begin
        if (inv_q.size() == 0) check("inv_extra", 64'(bus.tag_idx_o), 64'(NR_SETS));
        else check("inv_idx", 64'(bus.tag_idx_o), 64'(inv_q.pop_front()));
        m_valid[bus.tag_idx_o] = '0;
        m_dirty[bus.tag_idx_o] = '0;
      end else begin
        rd_nxt = 1'b1;
        rd_set_nxt = bus.tag_idx_o;
      end
    end
    if (bus.wb_req_o && wg) begin
      n_wb++;
      if (exp_q.size() == 0) check("wb_extra", 64'({bus.wb_way_o, bus.wb_addr_o}), 64'(0) - 1);
      else check("wb_req", 64'({bus.wb_way_o, bus.wb_addr_o}), 64'(exp_q.pop_front()));
    end
    if (walking && !start_now) stalls += int'(bus.tag_req_o && !tg) + int'(bus.wb_req_o && !wg);
    prev_wb_hold = bus.wb_req_o && !wg && !abort;
    prev_addr = bus.wb_addr_o;
    prev_way  = bus.wb_way_o;
    if (exp_ack) begin
      last_lat = cyc - start_cyc;
      walking = 1'b0;
      check("wb_left", 64'(exp_q.size()), 64'(0));
      check("inv_left", 64'(inv_q.size()), 64'(0));
    end
    if (abort) begin
      walking = 1'b0;
      exp_q.delete();
      inv_q.delete();
      check_idle_next = 1'b1;
      armed_m = 1'b1;
      rd_nxt = 1'b0;
    end else if (start_now) begin
      armed_m = 1'b0;
    end else if (!flush) begin
      armed_m = 1'b1;
    end
    rd_pend = rd_nxt;
    rd_set  = rd_set_nxt;
    @(posedge clk);
    #1;
    cyc++;
    if (abort) clr = 1'b0;
  endtask

  task automatic walk(input int budget);
    flush = 1'b1;
    cycle();
    for (int k = 0; k < budget && walking; k++) cycle();
    check("walk_done", 64'(walking), 64'(0));
    flush = 1'b0;
    cycle();
  endtask

  initial begin
    bus.tag_gnt_i = 1'b0;
    bus.wb_gnt_i = 1'b0;
    bus.tag_valid_i = '0;
    bus.tag_dirty_i = '0;
    bus.tag_rdata_i = '0;
    set_all(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 64'(state), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ack", 64'(flush_ack), 64'(0));
    check("rst_tag_req", 64'(bus.tag_req_o), 64'(0));
    check("rst_wb_req", 64'(bus.wb_req_o), 64'(0));
    check("rst_wb_addr", 64'(bus.wb_addr_o), 64'(0));
    rst_n = 1'b1;
    cycle();
    cycle();

    // Clean cache, flush held 20 cycles: one walk, ack at cycle 13, no restart
    flush = 1'b1;
    repeat (20) cycle();
    check("lat_clean", 64'(last_lat), 64'(13));
    check("wb_clean", 64'(n_wb), 64'(0));
    flush = 1'b0;
    cycle();

    // Set 2: way1 valid+dirty tag 0x5, way0 dirty but invalid
    set_all(1'b1, 1'b0);
    m_valid[2] = 2'b10;
    m_dirty[2] = 2'b11;
    m_tag[2][1] = 8'h05;
    walk(100);
    check("lat_one_dirty", 64'(last_lat), 64'(14));
    check("wb_one_dirty", 64'(n_wb), 64'(1));

    // Set 0 both dirty, write-back grant withheld 3 cycles
    set_all(1'b1, 1'b0);
    m_dirty[0] = 2'b11;
    wb_stall_left = 3;
    walk(100);
    check("lat_wb_stall", 64'(last_lat), 64'(18));

    // Tag grant withheld 2 cycles during the read of set 1
    set_all(1'b1, 1'b0);
    tag_stall_set = 2'd1;
    tag_stall_left = 2;
    walk(100);
    check("lat_tag_stall", 64'(last_lat), 64'(15));

    // Randomised contents and grant back-pressure
    for (int r = 0; r < 8; r++) begin
      fill_random();
      rand_pct = 15 * (r % 4);
      walk(400);
    end
    rand_pct = 0;

    // Synchronous clear while a write-back is pending, then a full fresh walk
    fill_random();
    m_valid[1] = 2'b11;
    m_dirty[1] = 2'b11;
    clr_on_wb = 1'b1;
    flush = 1'b1;
    for (int k = 0; k < 100 && (clr_on_wb || check_idle_next); k++) cycle();
    check("clr_seen", 64'(clr_on_wb), 64'(0));
    cycle();
    fill_random();
    walk(100);
    check("lat_post_clr", 64'(last_lat), 64'(CLEAN_LAT + n_dirty));

    // Asynchronous reset mid-walk drops everything at once
    set_all(1'b1, 1'b1);
    flush = 1'b1;
    repeat (5) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_tag_req", 64'(bus.tag_req_o), 64'(0));
    check("arst_wb_req", 64'(bus.wb_req_o), 64'(0));
    check("arst_ack", 64'(flush_ack), 64'(0));
    flush = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    walking = 1'b0;
    armed_m = 1'b1;
    rd_pend = 1'b0;
    prev_wb_hold = 1'b0;
    exp_q.delete();
    inv_q.delete();
    cycle();
    walk(100);
    check("lat_post_arst", 64'(last_lat), 64'(CLEAN_LAT + n_dirty));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
